// File: rtl/prog_loader_pkg.sv
// Shared types for the firmware loader: FSM states and error codes reported on the error output.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CSUM,
      S_VERIFY,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_LEN    = 2'd1;
   localparam logic [1:0] ERR_CSUM   = 2'd2;
   localparam logic [1:0] ERR_VERIFY = 2'd3;

endpackage

// File: rtl/prog_loader_byte_sum4.sv
// Combinational modulo-256 sum of the four bytes of a 32-bit word; zero latency, no flow control.
module byte_sum4 (
   input  logic [31:0] word_i,
   output logic [7:0]  sum_o
);

   assign sum_o = word_i[7:0] + word_i[15:8] + word_i[23:16] + word_i[31:24];

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory, verifies it by read-back,
// then releases the CPU from reset. rx_ready is high only while the loader is consuming the stream.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              reload,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              cpu_resetn,
   output logic              busy,
   output logic              done,
   output logic [1:0]        error
);

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [16:0]     CAP     = 17'(1) << ADDR_W;

   state_t            state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [23:0]       asm_q, asm_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic [7:0]        wsum_q, wsum_d;
   logic [7:0]        rsum_q, rsum_d;
   logic              rd_vld_q, rd_vld_d;
   logic              mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_resetn_q, cpu_resetn_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        error_q, error_d;

   logic [15:0]       n_full;
   logic              len_ok;
   logic              accept;
   logic [ADDR_W:0]   word_cnt_inc;
   logic [7:0]        rd_sum;

   byte_sum4 u_rd_sum (
      .word_i (mem_rdata),
      .sum_o  (rd_sum)
   );

   assign rx_ready     = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                         (state_q == S_DATA) || (state_q == S_CSUM);
   assign accept       = rx_valid && rx_ready;
   assign n_full       = {rx_data, len_lo_q};
   assign len_ok       = (n_full != 16'd0) && ({1'b0, n_full} <= CAP);
   assign word_cnt_inc = word_cnt_q + CNT_ONE;

   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      asm_d        = asm_q;
      byte_cnt_d   = byte_cnt_q;
      word_cnt_d   = word_cnt_q;
      wsum_d       = wsum_q;
      rsum_d       = rsum_q;
      rd_vld_d     = 1'b0;
      mem_wen_d    = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_resetn_d = cpu_resetn_q;
      busy_d       = busy_q;
      done_d       = done_q;
      error_d      = error_q;

      // Read data lags the issued address by one cycle.
      if (rd_vld_q) rsum_d = rsum_q + rd_sum;

      if (reload) begin
         state_d      = S_LEN0;
         wsum_d       = 8'd0;
         rsum_d       = 8'd0;
         done_d       = 1'b0;
         error_d      = ERR_NONE;
         cpu_resetn_d = 1'b0;
         busy_d       = 1'b0;
      end else begin
         case (state_q)
            S_LEN0: if (accept) begin
               len_lo_d = rx_data;
               busy_d   = 1'b1;
               state_d  = S_LEN1;
            end
            S_LEN1: if (accept) begin
               if (len_ok) begin
                  len_d      = n_full[ADDR_W:0];
                  word_cnt_d = '0;
                  byte_cnt_d = 2'd0;
                  state_d    = S_DATA;
               end else begin
                  error_d = ERR_LEN;
                  busy_d  = 1'b0;
                  state_d = S_ERROR;
               end
            end
            S_DATA: if (accept) begin
               wsum_d     = wsum_q + rx_data;
               asm_d      = {rx_data, asm_q[23:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  mem_wen_d   = 1'b1;
                  mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                  mem_wdata_d = {rx_data, asm_q};
                  word_cnt_d  = word_cnt_inc;
                  if (word_cnt_inc == len_q) state_d = S_CSUM;
               end
            end
            S_CSUM: if (accept) begin
               if (rx_data != wsum_q) begin
                  error_d = ERR_CSUM;
                  busy_d  = 1'b0;
                  state_d = S_ERROR;
               end else begin
                  mem_addr_d = '0;
                  word_cnt_d = '0;
                  rsum_d     = 8'd0;
                  state_d    = S_VERIFY;
               end
            end
            // One extra cycle after the last issue lets its read data land in rsum.
            S_VERIFY: begin
               if (word_cnt_q == len_q) begin
                  state_d = S_CHECK;
               end else begin
                  rd_vld_d   = 1'b1;
                  word_cnt_d = word_cnt_inc;
                  if (word_cnt_inc != len_q) mem_addr_d = word_cnt_inc[ADDR_W-1:0];
               end
            end
            S_CHECK: begin
               busy_d = 1'b0;
               if (rsum_q != wsum_q) begin
                  error_d = ERR_VERIFY;
                  state_d = S_ERROR;
               end else begin
                  done_d       = 1'b1;
                  cpu_resetn_d = 1'b1;
                  state_d      = S_DONE;
               end
            end
            S_DONE, S_ERROR: ;
            default: state_d = S_LEN0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_LEN0;
         len_lo_q     <= 8'd0;
         len_q        <= '0;
         asm_q        <= 24'd0;
         byte_cnt_q   <= 2'd0;
         word_cnt_q   <= '0;
         wsum_q       <= 8'd0;
         rsum_q       <= 8'd0;
         rd_vld_q     <= 1'b0;
         mem_wen_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         cpu_resetn_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         asm_q        <= asm_d;
         byte_cnt_q   <= byte_cnt_d;
         word_cnt_q   <= word_cnt_d;
         wsum_q       <= wsum_d;
         rsum_q       <= rsum_d;
         rd_vld_q     <= rd_vld_d;
         mem_wen_q    <= mem_wen_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_resetn_q <= cpu_resetn_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign mem_wen    = mem_wen_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_resetn = cpu_resetn_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random image streams against a stream-level reference model.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        reload = 1'b0;
   logic        rx_ready, mem_wen, cpu_resetn, busy, done;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [1:0]  error;

   int total = 0;
   int bad = 0;

   logic [31:0] mem [256];
   int          corrupt_idx = -1;
   logic [39:0] wr_log [$];
   logic [39:0] exp_wr [$];
   logic [7:0]  stream_q [$];
   int          exp_err, exp_lat, last_lat;

   prog_loader #(.ADDR_W(8)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .reload     (reload),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .cpu_resetn (cpu_resetn),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory; one selectable word reads back with bit 0 flipped.
   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      mem_rdata <= (int'(mem_addr) == corrupt_idx) ? (mem[mem_addr] ^ 32'h1) : mem[mem_addr];
   end

   always @(negedge clk) begin
      if (resetn && mem_wen === 1'b1) wr_log.push_back({mem_addr, mem_wdata});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (rx_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (rx_ready !== 1'b1) begin
         chk("rx_ready timeout", {63'd0, rx_ready}, 64'd1);
         rx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_all(input int max_gap);
      wr_log.delete();
      for (int i = 0; i < stream_q.size(); i++) begin
         send_byte(stream_q[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
         if (error != 2'd0) break;
      end
   endtask

   task automatic wait_end();
      int cyc;
      cyc = 0;
      while (!(done === 1'b1 || error !== 2'd0) && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      last_lat = cyc;
   endtask

   task automatic make_stream(input int n, input bit ramp, input logic [7:0] delta);
      logic [7:0]  s;
      logic [31:0] w;
      stream_q.delete();
      s = 8'd0;
      stream_q.push_back(n[7:0]);
      stream_q.push_back(n[15:8]);
      for (int k = 0; k < n; k++) begin
         w = ramp ? (32'(k) * 32'h01010101) : $urandom;
         for (int j = 0; j < 4; j++) begin
            stream_q.push_back(w[8*j +: 8]);
            s = s + w[8*j +: 8];
         end
      end
      stream_q.push_back(s + delta);
   endtask

   // Reference: parse the stream by its format rules and predict writes, outcome and latency.
   task automatic model();
      int          n;
      logic [7:0]  s;
      logic [31:0] w;
      exp_wr.delete();
      n = int'({stream_q[1], stream_q[0]});
      if (n < 1 || n > 256) begin
         exp_err = 1;
         exp_lat = 0;
         return;
      end
      s = 8'd0;
      for (int k = 0; k < n; k++) begin
         w = {stream_q[2+4*k+3], stream_q[2+4*k+2], stream_q[2+4*k+1], stream_q[2+4*k]};
         exp_wr.push_back({8'(k), w});
         for (int j = 0; j < 4; j++) s = s + stream_q[2+4*k+j];
      end
      if (stream_q[2+4*n] != s) begin
         exp_err = 2;
         exp_lat = 0;
      end else begin
         exp_err = (corrupt_idx >= 0 && corrupt_idx < n) ? 3 : 0;
         exp_lat = n + 2;
      end
   endtask

   task automatic check_result(input string tag);
      int first_bad;
      model();
      chk({tag, " write count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
      first_bad = -1;
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
         if (first_bad < 0 && wr_log[i] !== exp_wr[i]) first_bad = i;
      chk({tag, " first bad write"}, 64'(first_bad), 64'(-1));
      chk({tag, " error"}, {62'd0, error}, 64'(exp_err));
      chk({tag, " done"}, {63'd0, done}, (exp_err == 0) ? 64'd1 : 64'd0);
      chk({tag, " cpu_resetn"}, {63'd0, cpu_resetn}, (exp_err == 0) ? 64'd1 : 64'd0);
      chk({tag, " busy"}, {63'd0, busy}, 64'd0);
      chk({tag, " rx_ready"}, {63'd0, rx_ready}, 64'd0);
      chk({tag, " latency"}, 64'(last_lat), 64'(exp_lat));
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk("reload rx_ready", {63'd0, rx_ready}, 64'd1);
      chk("reload done", {63'd0, done}, 64'd0);
      chk("reload error", {62'd0, error}, 64'd0);
      chk("reload cpu_resetn", {63'd0, cpu_resetn}, 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " rx_ready"}, {63'd0, rx_ready}, 64'd1);
      chk({tag, " mem_wen"}, {63'd0, mem_wen}, 64'd0);
      chk({tag, " mem_addr"}, {56'd0, mem_addr}, 64'd0);
      chk({tag, " mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
      chk({tag, " cpu_resetn"}, {63'd0, cpu_resetn}, 64'd0);
      chk({tag, " busy"}, {63'd0, busy}, 64'd0);
      chk({tag, " done"}, {63'd0, done}, 64'd0);
      chk({tag, " error"}, {62'd0, error}, 64'd0);
   endtask

   initial begin
      logic [31:0] w0;
      int          n;

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      resetn = 1'b1;

      // N=1 directed, with write-timing checks around the 4th data byte.
      corrupt_idx = -1;
      stream_q = '{8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h0E};
      wr_log.delete();
      for (int i = 0; i < stream_q.size(); i++) begin
         send_byte(stream_q[i], 0);
         if (i == 0) chk("busy after first byte", {63'd0, busy}, 64'd1);
         if (i == 4) chk("no early wen", {63'd0, mem_wen}, 64'd0);
         if (i == 5) begin
            chk("wen after 4th byte", {63'd0, mem_wen}, 64'd1);
            chk("n1 mem_addr", {56'd0, mem_addr}, 64'd0);
            chk("n1 mem_wdata", {32'd0, mem_wdata}, 64'hAABBCCDD);
         end
      end
      wait_end();
      check_result("n1");

      // Full capacity with random rx_valid gaps.
      do_reload();
      make_stream(256, 1'b1, 8'd0);
      send_all(3);
      wait_end();
      check_result("n256");

      // Bad checksum.
      do_reload();
      stream_q = '{8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h0F};
      send_all(0);
      wait_end();
      check_result("bad csum");

      // Out-of-range lengths.
      do_reload();
      stream_q = '{8'h00, 8'h00};
      send_all(0);
      wait_end();
      check_result("len 0");
      do_reload();
      stream_q = '{8'h01, 8'h01};
      send_all(0);
      wait_end();
      check_result("len 257");

      // Corrupted read-back of word 3.
      do_reload();
      corrupt_idx = 3;
      make_stream(8, 1'b0, 8'd0);
      send_all(1);
      wait_end();
      check_result("verify corrupt");
      corrupt_idx = -1;

      // Reload after 6 data bytes of N=4, colliding with a byte that must be dropped.
      do_reload();
      make_stream(4, 1'b0, 8'd0);
      wr_log.delete();
      for (int i = 0; i < 8; i++) send_byte(stream_q[i], 0);
      w0 = {stream_q[5], stream_q[4], stream_q[3], stream_q[2]};
      chk("partial write count", 64'(wr_log.size()), 64'd1);
      if (wr_log.size() > 0) chk("partial write word0", {24'd0, wr_log[0]}, {24'd0, 8'h00, w0});
      @(negedge clk);
      rx_data  = 8'h05;
      rx_valid = 1'b1;
      reload   = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      reload   = 1'b0;
      chk("reload+byte rx_ready", {63'd0, rx_ready}, 64'd1);
      chk("reload+byte busy", {63'd0, busy}, 64'd0);
      chk("reload+byte cpu_resetn", {63'd0, cpu_resetn}, 64'd0);
      make_stream(1, 1'b0, 8'd0);
      send_all(0);
      wait_end();
      check_result("after reload");

      // Random streams: lengths, gaps, checksum faults and read corruption.
      for (int it = 0; it < 6; it++) begin
         do_reload();
         n = $urandom_range(1, 20);
         corrupt_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         make_stream(n, 1'b0, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
         send_all(2);
         wait_end();
         check_result("random");
      end
      corrupt_idx = -1;

      // Asynchronous reset in the middle of verify.
      do_reload();
      make_stream(64, 1'b0, 8'd0);
      send_all(0);
      repeat (20) @(posedge clk);
      #2;
      chk("pre-reset busy", {63'd0, busy}, 64'd1);
      chk("pre-reset rx_ready", {63'd0, rx_ready}, 64'd0);
      resetn = 1'b0;
      #1;
      chk_reset_outputs("mid-verify reset");
      @(negedge clk);
      resetn = 1'b1;

      make_stream(2, 1'b0, 8'd0);
      send_all(1);
      wait_end();
      check_result("post reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
